// File: rtl/cv32e40p_apu_issue_tracker.sv
// cv32e40p_apu_issue_tracker: in-order FPU issue gating and destination/write-back pairing.
// Define CV32E40P_APU_TRACKER_PERF_EN to build the saturating issue-stall counter.
module cv32e40p_apu_issue_tracker #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 6,
  parameter int LAT_W  = 2
) (
  input  logic                         clk,
  input  logic                         rst_ni,
  input  logic                         core_req_i,
  output logic                         core_gnt_o,
  input  logic [ADDR_W-1:0]            core_waddr_i,
  input  logic [LAT_W-1:0]             core_lat_i,
  output logic                         apu_req_o,
  input  logic                         apu_gnt_i,
  input  logic                         apu_rvalid_i,
  input  logic [31:0]                  apu_rdata_i,
  input  logic [4:0]                   apu_rflags_i,
  output logic                         wb_valid_o,
  output logic [ADDR_W-1:0]            wb_waddr_o,
  output logic [31:0]                  wb_rdata_o,
  output logic [4:0]                   wb_rflags_o,
  output logic                         busy_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         err_o,
  output logic [31:0]                  stall_cnt_o
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [ADDR_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wptr, r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic [LAT_W-1:0]  r_last_lat;
  logic              w_can_issue, w_push, w_pop;
  // last_lat is stale once the tracker drains, so an empty tracker accepts any class
  assign w_can_issue = (r_count < CNT_W'(DEPTH)) && ((r_count == '0) || (core_lat_i == r_last_lat));
  assign apu_req_o   = core_req_i && w_can_issue;
  assign core_gnt_o  = apu_req_o && apu_gnt_i;
  assign w_push      = core_gnt_o;
  assign w_pop       = apu_rvalid_i && (r_count != '0);
  assign count_o     = r_count;
  assign busy_o      = (r_count != '0) || wb_valid_o;
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= core_waddr_i;
  end
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_last_lat  <= '0;
      wb_valid_o  <= 1'b0;
      wb_waddr_o  <= '0;
      wb_rdata_o  <= '0;
      wb_rflags_o <= '0;
      err_o       <= 1'b0;
    end else begin
      r_count    <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      wb_valid_o <= w_pop;
      if (w_push) begin
        r_wptr     <= (r_wptr == PTR_W'(DEPTH - 1)) ? '0 : r_wptr + PTR_W'(1);
        r_last_lat <= core_lat_i;
      end
      if (w_pop) begin
        r_rptr      <= (r_rptr == PTR_W'(DEPTH - 1)) ? '0 : r_rptr + PTR_W'(1);
        wb_waddr_o  <= r_mem[r_rptr];
        wb_rdata_o  <= apu_rdata_i;
        wb_rflags_o <= apu_rflags_i;
      end
      if (apu_rvalid_i && (r_count == '0)) err_o <= 1'b1;
    end
  end
`ifdef CV32E40P_APU_TRACKER_PERF_EN
  logic [31:0] r_stall_cnt;
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) r_stall_cnt <= '0;
    else if (core_req_i && !w_can_issue && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 32'd1;
  end
  assign stall_cnt_o = r_stall_cnt;
`else
  assign stall_cnt_o = '0;
`endif
endmodule

// File: tb/tb_cv32e40p_apu_issue_tracker.sv
// tb_cv32e40p_apu_issue_tracker: queue-based reference model checked every cycle plus directed literal checks.
module tb_cv32e40p_apu_issue_tracker;
  localparam int DEPTH = 2;
  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        core_req_i = 1'b0, core_gnt_o;
  logic [5:0]  core_waddr_i = '0;
  logic [1:0]  core_lat_i = '0;
  logic        apu_req_o, apu_gnt_i = 1'b0;
  logic        apu_rvalid_i = 1'b0;
  logic [31:0] apu_rdata_i = '0;
  logic [4:0]  apu_rflags_i = '0;
  logic        wb_valid_o, busy_o, err_o;
  logic [5:0]  wb_waddr_o;
  logic [31:0] wb_rdata_o, stall_cnt_o;
  logic [4:0]  wb_rflags_o;
  logic [1:0]  count_o;
  int errors = 0;
  int checks = 0;
  cv32e40p_apu_issue_tracker #(.DEPTH(DEPTH), .ADDR_W(6), .LAT_W(2)) dut (
    .clk(clk), .rst_ni(rst_ni), .core_req_i(core_req_i), .core_gnt_o(core_gnt_o),
    .core_waddr_i(core_waddr_i), .core_lat_i(core_lat_i), .apu_req_o(apu_req_o),
    .apu_gnt_i(apu_gnt_i), .apu_rvalid_i(apu_rvalid_i), .apu_rdata_i(apu_rdata_i),
    .apu_rflags_i(apu_rflags_i), .wb_valid_o(wb_valid_o), .wb_waddr_o(wb_waddr_o),
    .wb_rdata_o(wb_rdata_o), .wb_rflags_o(wb_rflags_o), .busy_o(busy_o), .count_o(count_o),
    .err_o(err_o), .stall_cnt_o(stall_cnt_o)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  int          m_q[$];
  int          m_last_lat = 0;
  logic        m_wb_valid = 1'b0;
  int          m_wb_waddr = 0;
  logic [31:0] m_wb_rdata = '0;
  logic [4:0]  m_wb_rflags = '0;
  logic        m_err = 1'b0;
  longint      m_stall = 0;
  function automatic bit m_can();
    return (m_q.size() < DEPTH) && (m_q.size() == 0 || int'(core_lat_i) == m_last_lat);
  endfunction
  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      m_q.delete();
      m_last_lat = 0;
      m_wb_valid = 1'b0;
      m_wb_waddr = 0;
      m_wb_rdata = '0;
      m_wb_rflags = '0;
      m_err = 1'b0;
      m_stall = 0;
    end else begin
      automatic bit can  = m_can();
      automatic bit push = core_req_i && can && apu_gnt_i;
      automatic bit pop  = apu_rvalid_i && m_q.size() != 0;
      if (apu_rvalid_i && m_q.size() == 0) m_err = 1'b1;
`ifdef CV32E40P_APU_TRACKER_PERF_EN
      if (core_req_i && !can && m_stall < 64'hFFFF_FFFF) m_stall++;
`endif
      m_wb_valid = pop;
      if (pop) begin
        m_wb_waddr  = m_q.pop_front();
        m_wb_rdata  = apu_rdata_i;
        m_wb_rflags = apu_rflags_i;
      end
      if (push) begin
        m_q.push_back(int'(core_waddr_i));
        m_last_lat = int'(core_lat_i);
      end
    end
  end
  always @(negedge clk) begin
    automatic bit req = core_req_i && m_can();
    check("apu_req_o", apu_req_o, req);
    check("core_gnt_o", core_gnt_o, req && apu_gnt_i);
    check("count_o", count_o, m_q.size());
    check("wb_valid_o", wb_valid_o, m_wb_valid);
    check("wb_waddr_o", wb_waddr_o, m_wb_waddr);
    check("wb_rdata_o", wb_rdata_o, m_wb_rdata);
    check("wb_rflags_o", wb_rflags_o, m_wb_rflags);
    check("busy_o", busy_o, m_q.size() != 0 || m_wb_valid);
    check("err_o", err_o, m_err);
    check("stall_cnt_o", stall_cnt_o, m_stall);
  end
  task automatic set(input logic req, input logic [5:0] wa, input logic [1:0] lat, input logic gnt,
                     input logic rv, input logic [31:0] rd, input logic [4:0] rf);
    core_req_i = req; core_waddr_i = wa; core_lat_i = lat; apu_gnt_i = gnt;
    apu_rvalid_i = rv; apu_rdata_i = rd; apu_rflags_i = rf;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    set(0, 0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    idle();
    repeat (2) step();
    check("reset count", count_o, 0);
    check("reset wb_valid", wb_valid_o, 0);
    check("reset err", err_o, 0);
    rst_ni = 1'b1;
    step();
    set(1, 5, 0, 0, 0, 0, 0); #2;
    check("no gnt apu_req", apu_req_o, 1);
    check("no gnt core_gnt", core_gnt_o, 0);
    step();
    check("no gnt count", count_o, 0);
    set(1, 5, 0, 1, 0, 0, 0); #2;
    check("first gnt", core_gnt_o, 1);
    step();
    check("first count", count_o, 1);
    set(0, 0, 0, 0, 1, 32'h3F80_0000, 5'h01);
    step();
    check("first wb_valid", wb_valid_o, 1);
    check("first wb_waddr", wb_waddr_o, 5);
    check("first wb_rdata", wb_rdata_o, 32'h3F80_0000);
    idle(); step();
    check("wb hold valid", wb_valid_o, 0);
    check("wb hold waddr", wb_waddr_o, 5);
    set(1, 3, 0, 1, 0, 0, 0); step();
    set(1, 4, 0, 1, 0, 0, 0); step();
    check("full count", count_o, 2);
    set(1, 6, 0, 1, 0, 0, 0); #2;
    check("full blocked", apu_req_o, 0);
    step();
    set(1, 6, 0, 1, 1, 32'hAAAA_0001, 5'h02); #2;
    check("full no bypass", apu_req_o, 0);
    step();
    check("order wb 3", wb_waddr_o, 3);
    check("pop count", count_o, 1);
    set(1, 6, 0, 1, 1, 32'hBBBB_0002, 5'h04); #2;
    check("reissue", apu_req_o, 1);
    step();
    check("order wb 4", wb_waddr_o, 4);
    check("push+pop count", count_o, 1);
    set(0, 0, 0, 0, 1, 32'hCCCC_0003, 5'h08); step();
    check("drain wb 6", wb_waddr_o, 6);
    set(1, 7, 1, 1, 0, 0, 0); step();
    set(1, 8, 0, 1, 0, 0, 0); #2;
    check("lat block", apu_req_o, 0);
    step();
    set(1, 8, 0, 1, 1, 32'h4000_0000, 5'h10); #2;
    check("lat block at rvalid", apu_req_o, 0);
    step();
    check("lat drained count", count_o, 0);
    check("lat wb 7", wb_waddr_o, 7);
    set(1, 8, 0, 1, 0, 0, 0); #2;
    check("lat issue", apu_req_o, 1);
    step();
    for (int i = 0; i < 10; i++) begin
      set(1, 6'(11 + i), 0, 1, 1, 32'h100 + i, 5'(i));
      step();
      check("b2b count", count_o, 1);
      check("b2b wb_waddr", wb_waddr_o, (i == 0) ? 8 : 10 + i);
    end
    set(0, 0, 0, 0, 1, 32'h55, 5'h1F); step();
    check("b2b last", wb_waddr_o, 20);
    idle(); step();
    set(0, 0, 0, 0, 1, 32'h77, 0); step();
    check("stray wb_valid", wb_valid_o, 0);
    check("stray err", err_o, 1);
    idle(); repeat (3) step();
    check("err sticky", err_o, 1);
    rst_ni = 1'b0; #2;
    check("err cleared", err_o, 0);
    step(); rst_ni = 1'b1; step();
    set(1, 9, 1, 1, 0, 0, 0); step();
    set(1, 10, 0, 1, 0, 0, 0);
    repeat (7) step();
`ifdef CV32E40P_APU_TRACKER_PERF_EN
    check("stall count", stall_cnt_o, 7);
`else
    check("stall count", stall_cnt_o, 0);
`endif
    check("stall outstanding", count_o, 1);
    rst_ni = 1'b0; #2;
    check("midop reset count", count_o, 0);
    check("midop reset busy", busy_o, 0);
    idle(); step(); rst_ni = 1'b1; step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
